// File: rtl/muntjac_fpu_pkg.sv
// Shared FPU types: rounding modes, IEEE exception flags and the
// unrounded request bundle handed to the shared rounding datapath.
package muntjac_fpu_pkg;

    localparam int ReqExpWidth    = 13;
    localparam int ReqSigWidth    = 54;
    localparam int ReqTagWidth    = 5;
    localparam int DoubleExpWidth = 11;
    localparam int SingleExpWidth = 8;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } rounding_mode_e;

    typedef struct packed {
        logic invalid_operation;
        logic divide_by_zero;
        logic overflow;
        logic underflow;
        logic inexact;
    } exception_flags_t;

    // Value = significand * 2^(exponent - (ReqSigWidth-1)); MSB is the integer bit
    typedef struct packed {
        logic                          invalid_operation;
        logic                          divide_by_zero;
        logic                          use_nan_payload;
        logic                          double;
        logic                          sign;
        logic                          is_zero;
        logic                          is_nan;
        logic                          is_inf;
        logic signed [ReqExpWidth-1:0] exponent;
        logic [ReqSigWidth-1:0]        significand;
        rounding_mode_e                rounding_mode;
    } round_op_t;

    typedef struct packed {
        round_op_t              op;
        logic [ReqTagWidth-1:0] tag;
    } round_req_t;

endpackage

// File: rtl/muntjac_fpu_round_to_ieee_multi.sv
// Rounds one unrounded FPU result to both single and double precision
// and selects the format requested by the producer.
module muntjac_fpu_round_to_ieee_multi
    import muntjac_fpu_pkg::*;
(
    input  round_op_t        op,
    output logic [63:0]      ieee,
    output exception_flags_t exception
);

    function automatic logic [68:0] round_fmt(input round_op_t r, input logic dbl);
        logic [6:0]         m;
        logic [3:0]         e;
        logic signed [15:0] bias, biased;
        logic [15:0]        emax, shamt, ef;
        logic [127:0]       v, kept, rnd;
        logic [63:0]        fmask, res;
        logic               g, s, inc, tiny, ovf, to_inf;
        exception_flags_t   fl;

        m      = dbl ? 7'd52 : 7'd23;
        e      = dbl ? 4'(DoubleExpWidth) : 4'(SingleExpWidth);
        bias   = (16'sd1 <<< (e - 4'd1)) - 16'sd1;
        emax   = (16'd1 << e) - 16'd1;
        fmask  = (64'd1 << m) - 64'd1;
        biased = 16'(r.exponent) + bias;
        tiny   = biased < 16'sd1;
        shamt  = tiny ? 16'(16'sd1 - biased) : 16'd0;
        if (shamt > 16'd64) shamt = 16'd64;

        v    = {r.significand, {(128 - ReqSigWidth){1'b0}}} >> shamt;
        kept = v >> (7'd127 - m);
        g    = v[7'd126 - m];
        s    = |(v & ((128'd1 << (7'd126 - m)) - 128'd1));

        unique case (r.rounding_mode)
            RTZ:     inc = 1'b0;
            RDN:     inc = r.sign & (g | s);
            RUP:     inc = ~r.sign & (g | s);
            RMM:     inc = g;
            default: inc = g & (s | kept[0]);
        endcase

        // Subnormals carry into the exponent field through the integer bit
        rnd = kept + 128'(inc);
        ef  = tiny ? 16'(rnd[m]) : 16'(biased) + 16'(rnd[m + 7'd1]);
        ovf = !tiny && (ef >= emax);

        fl           = '0;
        fl.inexact   = g | s | ovf;
        fl.overflow  = ovf;
        // Tininess is detected before rounding
        fl.underflow = tiny & (g | s);
        res          = (64'(ef) << m) | (64'(rnd) & fmask);

        if (ovf) begin
            unique case (r.rounding_mode)
                RTZ:     to_inf = 1'b0;
                RDN:     to_inf = r.sign;
                RUP:     to_inf = ~r.sign;
                default: to_inf = 1'b1;
            endcase
            res = to_inf ? (64'(emax) << m) : ((64'(emax) << m) - 64'd1);
        end

        if (r.invalid_operation || r.is_nan) begin
            fl                   = '0;
            fl.invalid_operation = r.invalid_operation;
            res = (64'(emax) << m) | (64'd1 << (m - 7'd1));
            if (r.use_nan_payload)
                res = res | (64'(r.significand >> (7'(ReqSigWidth - 1) - m)) & fmask);
        end else if (r.is_inf) begin
            fl                = '0;
            fl.divide_by_zero = r.divide_by_zero;
            res               = 64'(emax) << m;
        end else if (r.is_zero) begin
            fl  = '0;
            res = '0;
        end

        if (!(r.invalid_operation || r.is_nan))
            res = res | (64'(r.sign) << (m + 7'(e)));
        if (!dbl) res[63:32] = '1;
        return {fl, res};
    endfunction

    logic [68:0] dres, sres;

    assign dres      = round_fmt(op, 1'b1);
    assign sres      = round_fmt(op, 1'b0);
    assign ieee      = op.double ? dres[63:0] : sres[63:0];
    assign exception = op.double ? dres[68:64] : sres[68:64];

endmodule

// File: rtl/muntjac_fpu_round_arbiter.sv
// Round-robin arbiter sharing one rounding datapath between FPU
// producers, with a registered, requester-tagged result.
module muntjac_fpu_round_arbiter
    import muntjac_fpu_pkg::*;
#(
    parameter int NumReq     = 3,
    parameter int InExpWidth = 13,
    parameter int InSigWidth = 54,
    parameter int TagWidth   = 5
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       flush_i,
    input  logic [NumReq-1:0]                          req_valid_i,
    output logic [NumReq-1:0]                          req_ready_o,
    input  logic [NumReq*(11+InExpWidth+InSigWidth+TagWidth)-1:0] req_i,
    output logic                                       resp_valid_o,
    input  logic                                       resp_ready_i,
    output logic [$clog2(NumReq)-1:0]                  resp_id_o,
    output logic [TagWidth-1:0]                        resp_tag_o,
    output logic [63:0]                                resp_ieee_o,
    output exception_flags_t                           resp_exception_o
);

    localparam int IdWidth = $clog2(NumReq);
    localparam int ReqBits = 11 + InExpWidth + InSigWidth + TagWidth;

    round_req_t       reqs [NumReq];
    round_req_t       gnt_req;
    logic [IdWidth-1:0] rr_q, gnt, rr_next;
    logic             any, accept;
    logic [63:0]      rnd_ieee;
    exception_flags_t rnd_exc;

    always_comb begin
        for (int i = 0; i < NumReq; i++)
            reqs[i] = round_req_t'(req_i[i*ReqBits +: ReqBits]);
    end

    // Scan from the far end so the nearest valid index at or after rr_q wins
    always_comb begin
        gnt = rr_q;
        any = 1'b0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_q) + k;
            if (idx >= NumReq) idx = idx - NumReq;
            if (req_valid_i[idx]) begin
                gnt = IdWidth'(idx);
                any = 1'b1;
            end
        end
    end

    assign accept  = any && (!resp_valid_o || resp_ready_i) && !flush_i && !rst_i;
    assign rr_next = (gnt == IdWidth'(NumReq - 1)) ? '0 : gnt + 1'b1;
    assign gnt_req = reqs[gnt];

    always_comb begin
        req_ready_o = '0;
        if (accept) req_ready_o[gnt] = 1'b1;
    end

    muntjac_fpu_round_to_ieee_multi u_round (
        .op        (gnt_req.op),
        .ieee      (rnd_ieee),
        .exception (rnd_exc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_o     <= 1'b0;
            resp_id_o        <= '0;
            resp_tag_o       <= '0;
            resp_ieee_o      <= '0;
            resp_exception_o <= '0;
            rr_q             <= '0;
        end else if (flush_i) begin
            resp_valid_o <= 1'b0;
            rr_q         <= '0;
        end else if (accept) begin
            resp_valid_o     <= 1'b1;
            resp_id_o        <= gnt;
            resp_tag_o       <= TagWidth'(gnt_req.tag);
            resp_ieee_o      <= rnd_ieee;
            resp_exception_o <= rnd_exc;
            rr_q             <= rr_next;
        end else if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_muntjac_fpu_round_arbiter.sv
// Directed bench for the shared FPU rounding arbiter.
module tb_muntjac_fpu_round_arbiter;
    import muntjac_fpu_pkg::*;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [2:0]       req_valid;
    logic [2:0]       req_ready;
    round_req_t       tb_req [3];
    logic [3*$bits(round_req_t)-1:0] req_flat;
    logic             resp_valid;
    logic             resp_ready;
    logic [1:0]       resp_id;
    logic [4:0]       resp_tag;
    logic [63:0]      resp_ieee;
    exception_flags_t resp_exc;

    int vectors;
    int miscompares;

    logic [63:0] exp_ieee [3];
    round_req_t  v_one_s, v_tie, v_tie_up, v_ovf, v_sub, v_dz;

    assign req_flat = {tb_req[2], tb_req[1], tb_req[0]};

    muntjac_fpu_round_arbiter dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .flush_i          (flush),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_i            (req_flat),
        .resp_valid_o     (resp_valid),
        .resp_ready_i     (resp_ready),
        .resp_id_o        (resp_id),
        .resp_tag_o       (resp_tag),
        .resp_ieee_o      (resp_ieee),
        .resp_exception_o (resp_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic round_req_t mk(input logic dbl, input logic sgn,
                                      input logic signed [12:0] ex,
                                      input logic [53:0] sig,
                                      input rounding_mode_e rm,
                                      input logic [4:0] tg);
        round_req_t r;
        r                  = '0;
        r.op.double        = dbl;
        r.op.sign          = sgn;
        r.op.exponent      = ex;
        r.op.significand   = sig;
        r.op.rounding_mode = rm;
        r.tag              = tg;
        return r;
    endfunction

    task automatic round_step(input string tag, input round_req_t r,
                              input logic [63:0] ieee, input logic [4:0] exc);
        tb_req[0]  = r;
        req_valid  = 3'b001;
        resp_ready = 1'b1;
        #1;
        check({tag, "_ready"}, 64'(req_ready), 64'h1);
        tick();
        req_valid = 3'b000;
        check({tag, "_ieee"}, resp_ieee, ieee);
        check({tag, "_exc"}, 64'(resp_exc), 64'(exc));
        check({tag, "_id"}, 64'(resp_id), 64'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        v_one_s  = mk(1'b0, 1'b0, 13'sd0, 54'h20000000000000, RNE, 5'd7);
        v_tie    = mk(1'b1, 1'b0, 13'sd0, 54'h20000000000001, RNE, 5'd3);
        v_tie_up = mk(1'b1, 1'b0, 13'sd0, 54'h20000000000001, RUP, 5'd3);
        v_ovf    = mk(1'b1, 1'b0, 13'sd1024, 54'h20000000000000, RNE, 5'd3);
        v_sub    = mk(1'b0, 1'b0, -13'sd127, 54'h20000000000000, RNE, 5'd3);
        v_dz     = mk(1'b1, 1'b1, 13'sd0, 54'h0, RNE, 5'd9);
        v_dz.op.is_inf         = 1'b1;
        v_dz.op.divide_by_zero = 1'b1;
        exp_ieee[0] = 64'h3ff0000000000000;
        exp_ieee[1] = 64'hffffffff3f800000;
        exp_ieee[2] = 64'hfff0000000000000;

        rst        = 1'b1;
        flush      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 3'b111;
        tb_req[0]  = '0;
        tb_req[1]  = '0;
        tb_req[2]  = '0;
        #2;
        check("rst_valid", 64'(resp_valid), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_ieee", resp_ieee, 64'd0);
        check("rst_tag", 64'(resp_tag), 64'd0);
        tick();
        rst       = 1'b0;
        req_valid = 3'b000;
        tick();

        tb_req[1] = v_one_s;
        req_valid = 3'b010;
        #1;
        check("single_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = 3'b000;
        check("single_valid", 64'(resp_valid), 64'd1);
        check("single_id", 64'(resp_id), 64'd1);
        check("single_tag", 64'(resp_tag), 64'd7);
        check("single_ieee", resp_ieee, 64'hffffffff3f800000);
        check("single_exc", 64'(resp_exc), 64'd0);

        tb_req[0] = v_tie;
        req_valid = 3'b001;
        flush     = 1'b1;
        #1;
        check("flush_ready", 64'(req_ready), 64'd0);
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(resp_valid), 64'd0);
        tb_req[2] = v_dz;
        req_valid = 3'b101;
        #1;
        check("flush_rr", 64'(req_ready), 64'h1);
        resp_ready = 1'b1;
        tick();
        req_valid = 3'b000;
        check("flush_next_id", 64'(resp_id), 64'd0);
        check("flush_next_tag", 64'(resp_tag), 64'd3);

        round_step("tie_rne", v_tie, 64'h3ff0000000000000, 5'b00001);
        round_step("tie_rup", v_tie_up, 64'h3ff0000000000001, 5'b00001);
        round_step("ovf", v_ovf, 64'h7ff0000000000000, 5'b00101);
        round_step("subn", v_sub, 64'hffffffff00400000, 5'b00000);
        tb_req[0] = v_tie;

        req_valid = 3'b100;
        #1;
        check("dz_ready", 64'(req_ready), 64'h4);
        tick();
        check("dz_ieee", resp_ieee, 64'hfff0000000000000);
        check("dz_exc", 64'(resp_exc), 64'b01000);
        check("dz_id", 64'(resp_id), 64'd2);

        resp_ready = 1'b0;
        req_valid  = 3'b111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_ieee", resp_ieee, 64'hfff0000000000000);
            check("bp_tag", 64'(resp_tag), 64'd9);
            tick();
        end

        resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            int e;
            e = k % 3;
            #1;
            check("rr_ready", 64'(req_ready), 64'd1 << e);
            tick();
            check("rr_id", 64'(resp_id), 64'(e));
            check("rr_ieee", resp_ieee, exp_ieee[e]);
        end

        resp_ready = 1'b0;
        req_valid  = 3'b111;
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 64'(resp_valid), 64'd0);
        check("arst_id", 64'(resp_id), 64'd0);
        check("arst_tag", 64'(resp_tag), 64'd0);
        check("arst_ieee", resp_ieee, 64'd0);
        check("arst_exc", 64'(resp_exc), 64'd0);
        check("arst_ready", 64'(req_ready), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
